// File: rtl/sevenseg_controller.sv
// Four-digit common-anode seven-segment scanner for a 12-bit value,
// shown as blanked-leading-zero decimal or three-digit hex.
module sevenseg_controller #(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SW7,
    input  logic [11:0] current_num,
    output logic [6:0]  SEG,
    output logic [3:0]  AN
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIGIT_CYCLES - 1);

    logic             sw7_q;
    logic [11:0]      num_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       digit_idx;
    logic [15:0]      bcd;
    logic [3:0]       nibble;
    logic             blank;
    logic [6:0]       seg_next;
    logic [3:0]       an_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Double-dabble binary to BCD: thousands in bcd[15:12], ones in bcd[3:0].
    always_comb begin
        bcd = '0;
        for (int i = 11; i >= 0; i--) begin
            for (int j = 0; j < 4; j++) begin
                if (bcd[j*4 +: 4] >= 4'd5)
                    bcd[j*4 +: 4] = bcd[j*4 +: 4] + 4'd3;
            end
            bcd = {bcd[14:0], num_q[i]};
        end
    end

    always_comb begin
        nibble = '0;
        blank  = 1'b0;
        if (sw7_q) begin
            case (digit_idx)
                2'd0:    nibble = num_q[3:0];
                2'd1:    nibble = num_q[7:4];
                2'd2:    nibble = num_q[11:8];
                default: blank  = 1'b1;
            endcase
        end else begin
            // A digit is blank when it and every more significant digit are zero.
            case (digit_idx)
                2'd0: nibble = bcd[3:0];
                2'd1: begin
                    nibble = bcd[7:4];
                    blank  = (bcd[15:4] == 12'd0);
                end
                2'd2: begin
                    nibble = bcd[11:8];
                    blank  = (bcd[15:8] == 8'd0);
                end
                default: begin
                    nibble = bcd[15:12];
                    blank  = (bcd[15:12] == 4'd0);
                end
            endcase
        end
        seg_next = blank ? 7'b1111111 : seg_decode(nibble);
        an_next  = blank ? 4'b1111 : ~(4'b0001 << digit_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw7_q     <= 1'b0;
            num_q     <= '0;
            cnt       <= CNT_LOAD;
            digit_idx <= 2'd0;
            SEG       <= 7'b1111111;
            AN        <= 4'b1111;
        end else begin
            sw7_q <= SW7;
            num_q <= current_num;
            if (cnt == '0) begin
                cnt       <= CNT_LOAD;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
            SEG <= seg_next;
            AN  <= an_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_controller.sv
// Scoreboard bench for sevenseg_controller: a cycle model predicts AN/SEG
// for every edge and the prediction is compared on the following negedge.
module tb_sevenseg_controller;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SW7 = 1'b0;
    logic [11:0] current_num = '0;
    logic [6:0]  SEG;
    logic [3:0]  AN;

    int n_vec = 0;
    int n_err = 0;

    logic [10:0] exp_q[$];

    logic        m_sw  = 1'b0;
    logic [11:0] m_num = '0;
    int          m_cnt = 0;
    int          m_idx = 0;

    sevenseg_controller #(.DIGIT_CYCLES(DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .SW7         (SW7),
        .current_num (current_num),
        .SEG         (SEG),
        .AN          (AN)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [10:0] ref_out(input logic sw, input logic [11:0] v, input int idx);
        int         vi;
        int         pw;
        int         d;
        bit         blank;
        logic [3:0] an_v;
        vi = int'(v);
        pw = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
        if (sw) begin
            blank = (idx == 3);
            d     = (vi >> (4 * idx)) & 15;
        end else begin
            blank = (idx > 0) && (vi < pw);
            d     = (vi / pw) % 10;
        end
        an_v = ~(4'b0001 << idx);
        if (blank) return {4'b1111, 7'b1111111};
        return {an_v, seg_of(d)};
    endfunction

    // Model of one rising edge: predict the outputs, then advance the model state.
    always @(posedge clk) begin
        logic [10:0] e;
        if (rst) begin
            e     = {4'b1111, 7'b1111111};
            m_sw  = 1'b0;
            m_num = '0;
            m_cnt = 0;
            m_idx = 0;
        end else begin
            e = ref_out(m_sw, m_num, m_idx);
            if (m_cnt == DC - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
            m_sw  = SW7;
            m_num = current_num;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        logic [10:0] e;
        check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an_seg", 32'({AN, SEG}), 32'(e));
            check("an_onehot", 32'($countones(~AN) <= 1), 32'd1);
        end
    end

    task automatic drive(input logic sw, input logic [11:0] v, input int n);
        @(negedge clk);
        SW7 = sw;
        current_num = v;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_edge", 32'({AN, SEG}), 32'({4'b1110, 7'b1000000}));
        repeat (16) @(posedge clk);

        drive(1'b0, 12'd1234, 24);
        drive(1'b0, 12'd7, 16);
        drive(1'b0, 12'd1000, 16);
        drive(1'b1, 12'hA5F, 16);
        drive(1'b1, 12'hBCE, 16);
        drive(1'b1, 12'hD09, 16);
        drive(1'b0, 12'd4095, 6);
        drive(1'b1, 12'd4095, 16);

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        for (int k = 0; k < 10; k++)
            drive(1'($urandom_range(0, 1)), 12'($urandom_range(0, 1000)), 5);

        repeat (20) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
